// File: rtl/irq_pkg.sv
// Shared types and constants for the four-line interrupt dispatcher.
package irq_pkg;

  localparam int NUM_IRQ  = 4;
  localparam int IRQ_ID_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } disp_state_t;

  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [NUM_IRQ-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/pri_enc4.sv
// Four-input combinational priority encoder; req[3] has the highest priority.
module pri_enc4
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0]  req,
  output logic                any,
  output logic [IRQ_ID_W-1:0] code
);

  always_comb begin
    any  = |req;
    code = 2'b00;
    if (req[3])      code = 2'b11;
    else if (req[2]) code = 2'b10;
    else if (req[1]) code = 2'b01;
  end

endmodule

// File: rtl/irq_dispatch4.sv
// Captures request edges into sticky pending bits and dispatches the highest
// enabled one over a valid/ack handshake, with a hold-off after each ack.
module irq_dispatch4
  import irq_pkg::*;
#(
  parameter int HOLDOFF_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq,
  input  logic [NUM_IRQ-1:0]  en,
  input  logic                int_ack,
  input  logic                ovf_clr,
  output logic                int_valid,
  output logic [IRQ_ID_W-1:0] int_id,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  ovf
);

  generate
    if (HOLDOFF_CYC < 0 || HOLDOFF_CYC > 15) begin : g_bad_holdoff
      $error("irq_dispatch4: HOLDOFF_CYC must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] HOLD_LOAD = (HOLDOFF_CYC == 0) ? 4'd0 : 4'(HOLDOFF_CYC - 1);

  disp_state_t        state;
  logic [3:0]         hold_cnt;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [NUM_IRQ-1:0] ovf_set;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic [NUM_IRQ-1:0] ovf_nxt;
  logic               enc_any;
  logic [IRQ_ID_W-1:0] enc_code;
  logic               ack_take;

  pri_enc4 u_enc (
    .req  (pending & en),
    .any  (enc_any),
    .code (enc_code)
  );

  // A bit being acked this edge is not "already pending" for overflow purposes,
  // and a fresh rise on it overrides the clear.
  always_comb begin
    rise        = irq & ~irq_q;
    ack_take    = (state == PRESENT) && int_ack;
    ack_clr     = ack_take ? id_onehot(int_id) : '0;
    ovf_set     = rise & pending & ~ack_clr;
    pending_nxt = (pending & ~ack_clr) | rise;
    ovf_nxt     = (ovf & {NUM_IRQ{~ovf_clr}}) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      ovf     <= '0;
    end else begin
      irq_q   <= irq;
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      int_valid <= 1'b0;
      int_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enc_any) begin
            int_id    <= enc_code;
            int_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (int_ack) begin
            int_valid <= 1'b0;
            if (HOLDOFF_CYC == 0) begin
              state <= IDLE;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt == 4'd0) state <= IDLE;
          else                  hold_cnt <= hold_cnt - 4'd1;
        end
        default: begin
          state     <= IDLE;
          int_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_dispatch4.sv
// Directed bench for irq_dispatch4 with HOLDOFF_CYC=1.
module tb_irq_dispatch4;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq;
  logic [3:0] en;
  logic       int_ack;
  logic       ovf_clr;
  logic       int_valid;
  logic [1:0] int_id;
  logic [3:0] pending;
  logic [3:0] ovf;

  int checks;
  int failures;

  irq_dispatch4 #(.HOLDOFF_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq       (irq),
    .en        (en),
    .int_ack   (int_ack),
    .ovf_clr   (ovf_clr),
    .int_valid (int_valid),
    .int_id    (int_id),
    .pending   (pending),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs and samples sit 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0; irq = 4'b0000; en = 4'b0000; int_ack = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", {7'd0, int_valid}, 8'd0);
    chk("rst_id", {6'd0, int_id}, 8'd0);
    chk("rst_pending", {4'd0, pending}, 8'd0);
    chk("rst_ovf", {4'd0, ovf}, 8'd0);
    rst_n = 1'b1; en = 4'b1111;
    tick();

    // single request
    irq = 4'b0100; tick();
    chk("t1_pend", {4'd0, pending}, 8'b0100);
    chk("t1_valid_early", {7'd0, int_valid}, 8'd0);
    irq = 4'b0000; tick();
    chk("t1_valid", {7'd0, int_valid}, 8'd1);
    chk("t1_id", {6'd0, int_id}, 8'b10);
    int_ack = 1'b1; tick();
    chk("t1_pend_clr", {4'd0, pending}, 8'd0);
    chk("t1_valid_clr", {7'd0, int_valid}, 8'd0);
    int_ack = 1'b0; tick(); tick();

    // priority and hold-off length
    irq = 4'b0011; tick();
    chk("t2_pend", {4'd0, pending}, 8'b0011);
    irq = 4'b0000; tick();
    chk("t2_id1", {5'd0, int_valid, int_id}, 8'b101);
    int_ack = 1'b1; tick();
    chk("t2_ack_valid", {7'd0, int_valid}, 8'd0);
    chk("t2_ack_pend", {4'd0, pending}, 8'b0001);
    int_ack = 1'b0; tick();
    chk("t2_hold_valid", {7'd0, int_valid}, 8'd0);
    tick();
    chk("t2_id0", {5'd0, int_valid, int_id}, 8'b100);

    // no pre-emption
    irq = 4'b1000; tick();
    chk("t3_pend", {4'd0, pending}, 8'b1001);
    chk("t3_frozen_a", {5'd0, int_valid, int_id}, 8'b100);
    irq = 4'b0000; tick();
    chk("t3_frozen_b", {5'd0, int_valid, int_id}, 8'b100);
    int_ack = 1'b1; tick();
    chk("t3_ack_pend", {4'd0, pending}, 8'b1000);
    int_ack = 1'b0; tick(); tick();
    chk("t3_id3", {5'd0, int_valid, int_id}, 8'b111);
    int_ack = 1'b1; tick();
    chk("t3_pend_end", {4'd0, pending}, 8'd0);
    int_ack = 1'b0; tick(); tick();

    // masking, and ack while idle is ignored
    en = 4'b0111; irq = 4'b1000; tick();
    chk("t4_pend", {4'd0, pending}, 8'b1000);
    irq = 4'b0000; tick();
    chk("t4_masked_a", {7'd0, int_valid}, 8'd0);
    int_ack = 1'b1; tick();
    chk("t4_masked_b", {7'd0, int_valid}, 8'd0);
    chk("t4_idle_ack", {4'd0, pending}, 8'b1000);
    int_ack = 1'b0; en = 4'b1111; tick();
    chk("t4_unmask", {5'd0, int_valid, int_id}, 8'b111);
    int_ack = 1'b1; tick();
    int_ack = 1'b0; tick(); tick();

    // overflow, ovf_clr, same-edge set/clear
    irq = 4'b0100; tick();
    irq = 4'b0000; tick();
    chk("t5_present", {5'd0, int_valid, int_id}, 8'b110);
    irq = 4'b0100; tick();
    chk("t5_ovf", {4'd0, ovf}, 8'b0100);
    chk("t5_ovf_pend", {4'd0, pending}, 8'b0100);
    irq = 4'b0000; ovf_clr = 1'b1; tick();
    chk("t5_ovf_clr", {4'd0, ovf}, 8'd0);
    ovf_clr = 1'b0;
    irq = 4'b0100; int_ack = 1'b1; tick();
    chk("t5_same_pend", {4'd0, pending}, 8'b0100);
    chk("t5_same_ovf", {4'd0, ovf}, 8'd0);
    chk("t5_same_valid", {7'd0, int_valid}, 8'd0);
    irq = 4'b0000; int_ack = 1'b0; tick(); tick();
    chk("t5_redisp", {5'd0, int_valid, int_id}, 8'b110);
    irq = 4'b0100; ovf_clr = 1'b1; tick();
    chk("t5_clr_vs_set", {4'd0, ovf}, 8'b0100);
    irq = 4'b0000; tick();
    chk("t5_clr_done", {4'd0, ovf}, 8'd0);
    ovf_clr = 1'b0; int_ack = 1'b1; tick();
    int_ack = 1'b0; tick(); tick();

    // asynchronous reset mid-operation
    irq = 4'b1010; tick();
    chk("t6_pend", {4'd0, pending}, 8'b1010);
    tick();
    chk("t6_present", {5'd0, int_valid, int_id}, 8'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {7'd0, int_valid}, 8'd0);
    chk("t6_async_pend", {4'd0, pending}, 8'd0);
    chk("t6_async_ovf", {4'd0, ovf}, 8'd0);
    tick();
    rst_n = 1'b1; tick();
    chk("t6_recapture", {4'd0, pending}, 8'b1010);
    tick();
    chk("t6_redisp", {5'd0, int_valid, int_id}, 8'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
